pipe_io_controller: RTL and testbench
=====================================

// Module: pipe_io_controller
// PURPOSE
//  Memory-mapped I/O controller between the pipelined CPU's MEM stage and the board I/O.
//  It synchronises and debounces sw[9:0] and key[3:1], latches sticky key-press events,
//  and holds the led and six 7-segment digit registers.
//  A fixed one-cycle request/ready handshake sequences every CPU access.
// PARAMETERS
//  DB_CYCLES  4   consecutive stable cycles before a debounced input changes (>=1)
//  DB_W       16  debounce counter width; must satisfy DB_CYCLES < 2**DB_W
// PORTS
//  clk        in   1   system clock; all state on rising edge
//  reset      in   1   asynchronous, active-high reset
//  io_cs      in   1   access request; held by CPU until io_ready
//  io_we      in   1   1=write, 0=read; qualified by io_cs
//  io_addr    in   6   byte offset in I/O window; bits[1:0] ignored
//  io_wdata   in   32  write data
//  io_rdata   out  32  read data; valid while io_ready=1
//  io_ready   out  1   one-cycle access acknowledge
//  sw         in   10  raw slide switches, asynchronous
//  key        in   3   raw push buttons key[3:1], active-low, asynchronous
//  hex5..hex0 out  7   per digit, active-low segments {g,f,e,d,c,b,a}
//  led        out  10  LED register
//  key_irq    out  1   OR of all pending key events
// BEHAVIOUR
//  Reset values: hex*=7'h7F (blank), led=0, io_rdata=0, io_ready=0, key_irq=0.
//    Internal reset: sw sync flops=0, key sync flops=1 (released), debounced sw=0,
//    pressed=0, counters=0, events=0, digit regs=5'h10.
//  Register map (byte offset):
//    0x00 SW       RO    rdata[9:0]=debounced sw
//    0x04 KEY      RO    rdata[2:0]=pressed {k3,k2,k1}
//    0x08 KEY_EVT  R/W1C rdata[2:0]=sticky events
//    0x0C LED      R/W   bits[9:0]
//    0x10..0x24 HEX0..HEX5  R/W  bit4=blank, bits[3:0]=hex value
//  Unused rdata bits read 0. Unmapped offsets read 0, ignore writes, and are still acked.
//  Handshake FSM:
//    IDLE: io_cs=1 -> ACK. On this edge: a write commits, or a read's data is registered into io_rdata.
//    ACK:  io_ready=1 for exactly one cycle, io_cs ignored; next state IDLE unconditionally.
//    Back-to-back accesses: ready pulses every 2 cycles. io_rdata returns to 0 in IDLE.
//  Input path, per bit: 2-flop synchroniser -> debouncer.
//    The debouncer counts cycles where synced != stable and clears the count on agreement.
//    At count==DB_CYCLES, stable takes the synced value and the count clears.
//    A clean raw edge appears on stable exactly 2+DB_CYCLES cycles later.
//    Pulses shorter than DB_CYCLES cycles are never seen.
//  pressed = debounced ~key.
//    A 0->1 pressed edge sets the matching event bit; KEY_EVT write-1 clears it.
//    Same-cycle set and clear of a bit: set wins.
//  Digit decode, combinational from the register:
//    blank ? 7'h7F : seg(value); seg(0)=7'b1000000, seg(5)=7'b0010010, seg(F)=7'b0001110.
//  key_irq = |events, registered with the events.
//  Reset asserted mid-access: FSM forced to IDLE and the access is dropped; the CPU re-issues it.
// STRUCTURE
//  Package pipe_io_pkg: register offset constants, FSM state enum (IDLE/ACK),
//    seg7 decode function, reset constants.
//  Sub-module io_debounce (params DB_CYCLES, DB_W): 1-bit synchroniser plus debouncer,
//    with a SYNC_RST_VAL parameter for reset polarity; instantiated 13 times.
//  Top level holds the FSM, register file, event logic and decoders.
// TESTING
//  1 Assert reset mid-run -> hex*=7'h7F, led=0, io_ready=0, key_irq=0 immediately, without a clock edge.
//  2 sw=10'b1010101010, key=3'b111; wait 2+DB_CYCLES; read 0x00 -> io_ready exactly 1 cycle after io_cs, io_rdata=32'h2AA.
//  3 key=3'b011 held -> after 6 cycles key_irq=1; read 0x04=3'b100 and 0x08=3'b100; write 0x08 with 3'b100 -> key_irq=0.
//  4 key1 low for DB_CYCLES-1 cycles, then high -> KEY reads 0, KEY_EVT unchanged, no key_irq.
//  5 write 0x10=5'h05 -> hex0=7'b0010010; write 0x24=5'h10 -> hex5=7'h7F; write LED=32'hFFFF_FFFF -> led=10'h3FF, readback 32'h3FF.
//  6 W1C of bit0 on the cycle key1's debounced press edge lands -> bit0 stays 1. Unmapped 0x3C: read=0, write ignored, still acked.

Source files
------------

// File: rtl/pipe_io_pkg.sv
// Shared definitions for the pipelined CPU's memory-mapped I/O controller:
// register offsets, handshake states, reset constants and the 7-segment decoder.
package pipe_io_pkg;

    localparam int SW_W       = 10;
    localparam int KEY_W      = 3;
    localparam int LED_W      = 10;
    localparam int NUM_DIGITS = 6;
    localparam int DIGIT_W    = 5;

    localparam logic [5:0] ADDR_MASK    = 6'h3C;
    localparam logic [5:0] ADDR_SW      = 6'h00;
    localparam logic [5:0] ADDR_KEY     = 6'h04;
    localparam logic [5:0] ADDR_KEY_EVT = 6'h08;
    localparam logic [5:0] ADDR_LED     = 6'h0C;
    localparam logic [5:0] ADDR_HEX0    = 6'h10;

    localparam logic [DIGIT_W-1:0] DIGIT_RST = 5'h10;
    localparam logic [6:0]         SEG_BLANK = 7'h7F;

    typedef enum logic {
        IDLE,
        ACK
    } io_state_t;

    function automatic logic [5:0] hex_addr(input int idx);
        return ADDR_HEX0 + 6'(4 * idx);
    endfunction

    // Active-low segments {g,f,e,d,c,b,a}; bit 4 of the digit register blanks the digit.
    function automatic logic [6:0] seg7(input logic [DIGIT_W-1:0] digit);
        logic [6:0] seg;
        if (digit[4]) begin
            seg = SEG_BLANK;
        end else begin
            case (digit[3:0])
                4'h0: seg = 7'b1000000;
                4'h1: seg = 7'b1111001;
                4'h2: seg = 7'b0100100;
                4'h3: seg = 7'b0110000;
                4'h4: seg = 7'b0011001;
                4'h5: seg = 7'b0010010;
                4'h6: seg = 7'b0000010;
                4'h7: seg = 7'b1111000;
                4'h8: seg = 7'b0000000;
                4'h9: seg = 7'b0010000;
                4'hA: seg = 7'b0001000;
                4'hB: seg = 7'b0000011;
                4'hC: seg = 7'b1000110;
                4'hD: seg = 7'b0100001;
                4'hE: seg = 7'b0000110;
                default: seg = 7'b0001110;
            endcase
        end
        return seg;
    endfunction

endpackage

// File: rtl/io_debounce.sv
// One input bit: two-flop synchroniser followed by a stability-count debouncer.
// commit pulses combinationally on the cycle whose clock edge updates stable.
module io_debounce
    import pipe_io_pkg::*;
#(
    parameter int   DB_CYCLES    = 4,
    parameter int   DB_W         = 16,
    parameter logic SYNC_RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic stable,
    output logic commit
);

    localparam logic [DB_W-1:0] LAST_COUNT = DB_W'(DB_CYCLES - 1);

    logic            sync_q1;
    logic            sync_q2;
    logic [DB_W-1:0] count;

    assign commit = (sync_q2 != stable) && (count == LAST_COUNT);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q1 <= SYNC_RST_VAL;
            sync_q2 <= SYNC_RST_VAL;
            stable  <= SYNC_RST_VAL;
            count   <= '0;
        end else begin
            sync_q1 <= raw;
            sync_q2 <= sync_q1;
            if (sync_q2 == stable) begin
                count <= '0;
            end else if (commit) begin
                stable <= sync_q2;
                count  <= '0;
            end else begin
                count <= count + DB_W'(1);
            end
        end
    end

endmodule

// File: rtl/pipe_io_controller.sv
// Memory-mapped I/O block for the CPU's MEM stage: debounced switches and keys,
// sticky key events, LED and six 7-segment digit registers behind a one-cycle handshake.
module pipe_io_controller
    import pipe_io_pkg::*;
#(
    parameter int DB_CYCLES = 4,
    parameter int DB_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              io_cs,
    input  logic              io_we,
    input  logic [5:0]        io_addr,
    input  logic [31:0]       io_wdata,
    output logic [31:0]       io_rdata,
    output logic              io_ready,
    input  logic [SW_W-1:0]   sw,
    input  logic [KEY_W-1:0]  key,
    output logic [6:0]        hex0,
    output logic [6:0]        hex1,
    output logic [6:0]        hex2,
    output logic [6:0]        hex3,
    output logic [6:0]        hex4,
    output logic [6:0]        hex5,
    output logic [LED_W-1:0]  led,
    output logic              key_irq
);

    io_state_t state, state_next;

    logic [SW_W-1:0]    sw_stable;
    logic [SW_W-1:0]    sw_commit_unused;
    logic [KEY_W-1:0]   key_stable;
    logic [KEY_W-1:0]   key_commit;
    logic [KEY_W-1:0]   key_pressed;
    logic [KEY_W-1:0]   key_press_edge;
    logic [KEY_W-1:0]   events;
    logic [KEY_W-1:0]   events_next;
    logic [KEY_W-1:0]   evt_clr;
    logic [DIGIT_W-1:0] digits [NUM_DIGITS];
    logic [5:0]         word_addr;
    logic [31:0]        rdata_next;
    logic               access_fire;
    logic               wr_fire;
    logic               wdata_unused;

    // Switches rest low, keys rest high (released); the sync chains reset to the resting level.
    for (genvar i = 0; i < SW_W; i++) begin : g_sw_db
        io_debounce #(
            .DB_CYCLES   (DB_CYCLES),
            .DB_W        (DB_W),
            .SYNC_RST_VAL(1'b0)
        ) u_sw_db (
            .clk   (clk),
            .reset (reset),
            .raw   (sw[i]),
            .stable(sw_stable[i]),
            .commit(sw_commit_unused[i])
        );
    end

    for (genvar i = 0; i < KEY_W; i++) begin : g_key_db
        io_debounce #(
            .DB_CYCLES   (DB_CYCLES),
            .DB_W        (DB_W),
            .SYNC_RST_VAL(1'b1)
        ) u_key_db (
            .clk   (clk),
            .reset (reset),
            .raw   (key[i]),
            .stable(key_stable[i]),
            .commit(key_commit[i])
        );
    end

    assign key_pressed    = ~key_stable;
    // A commit while currently released is the press edge, caught on the same edge it lands.
    assign key_press_edge = key_commit & key_stable;

    assign word_addr    = io_addr & ADDR_MASK;
    assign access_fire  = (state == IDLE) && io_cs;
    assign wr_fire      = access_fire && io_we;
    assign io_ready     = (state == ACK);
    assign wdata_unused = ^io_wdata[31:LED_W];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (io_cs) state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        rdata_next = '0;
        case (word_addr)
            ADDR_SW:      rdata_next[SW_W-1:0]  = sw_stable;
            ADDR_KEY:     rdata_next[KEY_W-1:0] = key_pressed;
            ADDR_KEY_EVT: rdata_next[KEY_W-1:0] = events;
            ADDR_LED:     rdata_next[LED_W-1:0] = led;
            default: begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (word_addr == hex_addr(i)) rdata_next[DIGIT_W-1:0] = digits[i];
                end
            end
        endcase
    end

    always_comb begin
        evt_clr = '0;
        if (wr_fire && (word_addr == ADDR_KEY_EVT)) evt_clr = io_wdata[KEY_W-1:0];
        events_next = (events & ~evt_clr) | key_press_edge;
    end

    // NOTE: the six digit registers are plain flops, so they take a reset value and blank at power-up.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led      <= '0;
            events   <= '0;
            key_irq  <= 1'b0;
            io_rdata <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) digits[i] <= DIGIT_RST;
        end else begin
            events   <= events_next;
            key_irq  <= |events_next;
            io_rdata <= (access_fire && !io_we) ? rdata_next : '0;
            if (wr_fire && (word_addr == ADDR_LED)) led <= io_wdata[LED_W-1:0];
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (wr_fire && (word_addr == hex_addr(i))) digits[i] <= io_wdata[DIGIT_W-1:0];
            end
        end
    end

    assign hex0 = seg7(digits[0]);
    assign hex1 = seg7(digits[1]);
    assign hex2 = seg7(digits[2]);
    assign hex3 = seg7(digits[3]);
    assign hex4 = seg7(digits[4]);
    assign hex5 = seg7(digits[5]);

endmodule

// File: tb/tb_pipe_io_controller.sv
// Self-checking bench for pipe_io_controller: directed scenarios plus randomized
// register traffic checked against a behavioural register/display model.
module tb_pipe_io_controller;

    localparam int DB_CYCLES = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        io_cs;
    logic        io_we;
    logic [5:0]  io_addr;
    logic [31:0] io_wdata;
    logic [31:0] io_rdata;
    logic        io_ready;
    logic [9:0]  sw;
    logic [2:0]  key;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
    logic [9:0]  led;
    logic        key_irq;

    logic [6:0]  hex_pins [6];
    assign hex_pins[0] = hex0;
    assign hex_pins[1] = hex1;
    assign hex_pins[2] = hex2;
    assign hex_pins[3] = hex3;
    assign hex_pins[4] = hex4;
    assign hex_pins[5] = hex5;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference model: what software last wrote, and the segment pattern per hex value.
    logic [9:0] led_m;
    logic [4:0] dig_m [6];
    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    pipe_io_controller #(.DB_CYCLES(DB_CYCLES), .DB_W(16)) dut (
        .clk(clk), .reset(reset), .io_cs(io_cs), .io_we(io_we), .io_addr(io_addr),
        .io_wdata(io_wdata), .io_rdata(io_rdata), .io_ready(io_ready), .sw(sw), .key(key),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5),
        .led(led), .key_irq(key_irq)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] exp_hex(input logic [4:0] d);
        return d[4] ? 7'h7F : seg_tab[d[3:0]];
    endfunction

    // Issue one access at the current negedge; return with the FSM back in IDLE.
    task automatic access(input logic we, input logic [5:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata);
        int waited = 0;
        io_cs = 1'b1; io_we = we; io_addr = addr; io_wdata = wdata;
        do begin
            @(posedge clk); @(negedge clk); waited++;
        end while (io_ready !== 1'b1 && waited < 4);
        total_cnt++;
        if (io_ready !== 1'b1 || waited != 1)
            $display("FAIL ack_latency addr=%h: ready=%b after %0d cycles, expected 1 after 1 cycle",
                     addr, io_ready, waited);
        else pass_cnt++;
        rdata = io_rdata;
        io_cs = 1'b0; io_we = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (io_ready !== 1'b0 || io_rdata !== 32'h0)
            $display("FAIL ack_single_cycle addr=%h: ready=%b rdata=%h, expected ready=0 rdata=0",
                     addr, io_ready, io_rdata);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        reset = 1'b1; io_cs = 1'b0; io_we = 1'b0; io_addr = '0; io_wdata = '0;
        sw = '0; key = 3'b111;
        led_m = '0;
        for (int i = 0; i < 6; i++) dig_m[i] = 5'h10;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (io_ready !== 1'b0 || io_rdata !== 32'h0 || led !== 10'h0 || key_irq !== 1'b0)
            $display("FAIL reset_outputs: ready=%b rdata=%h led=%h irq=%b, expected all 0",
                     io_ready, io_rdata, led, key_irq);
        else pass_cnt++;
        for (int i = 0; i < 6; i++) begin
            total_cnt++;
            if (hex_pins[i] !== 7'h7F) $display("FAIL reset_hex%0d: got %h expected 7f", i, hex_pins[i]);
            else pass_cnt++;
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        access(1'b0, 6'h04, '0, rd);
        total_cnt++;
        if (rd !== 32'h0) $display("FAIL reset_key_read: got %h expected 0", rd); else pass_cnt++;
        access(1'b0, 6'h10, '0, rd);
        total_cnt++;
        if (rd !== 32'h10) $display("FAIL reset_hex0_read: got %h expected 10", rd); else pass_cnt++;
    endtask

    task automatic test_sw();
        logic [31:0] rd;
        sw = 10'b1010101010;
        repeat (2 + DB_CYCLES) @(negedge clk);
        access(1'b0, 6'h00, '0, rd);
        total_cnt++;
        if (rd !== 32'h2AA) $display("FAIL sw_read: got %h expected 2aa", rd); else pass_cnt++;
        // Read landing on the very edge that updates the debounced value still sees the old one.
        sw = 10'h000;
        repeat (1 + DB_CYCLES) @(negedge clk);
        access(1'b0, 6'h00, '0, rd);
        total_cnt++;
        if (rd !== 32'h2AA) $display("FAIL sw_edge_read: got %h expected 2aa", rd); else pass_cnt++;
        access(1'b0, 6'h00, '0, rd);
        total_cnt++;
        if (rd !== 32'h0) $display("FAIL sw_settled_read: got %h expected 0", rd); else pass_cnt++;
    endtask

    task automatic test_key_event();
        logic [31:0] rd;
        key = 3'b011;
        repeat (5) @(negedge clk);
        total_cnt++;
        if (key_irq !== 1'b0) $display("FAIL key_irq_early: got %b expected 0", key_irq); else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (key_irq !== 1'b1) $display("FAIL key_irq_set: got %b expected 1", key_irq); else pass_cnt++;
        access(1'b0, 6'h04, '0, rd);
        total_cnt++;
        if (rd !== 32'h4) $display("FAIL key_pressed_read: got %h expected 4", rd); else pass_cnt++;
        access(1'b0, 6'h08, '0, rd);
        total_cnt++;
        if (rd !== 32'h4) $display("FAIL key_evt_read: got %h expected 4", rd); else pass_cnt++;
        access(1'b1, 6'h08, 32'h4, rd);
        total_cnt++;
        if (key_irq !== 1'b0) $display("FAIL key_w1c_irq: got %b expected 0", key_irq); else pass_cnt++;
        key = 3'b111;
        repeat (2 * DB_CYCLES) @(negedge clk);
        access(1'b0, 6'h08, '0, rd);
        total_cnt++;
        if (rd !== 32'h0 || key_irq !== 1'b0)
            $display("FAIL key_release_evt: evt=%h irq=%b expected 0/0", rd, key_irq);
        else pass_cnt++;
    endtask

    task automatic test_glitch();
        logic [31:0] rd;
        key = 3'b110;
        repeat (DB_CYCLES - 1) @(negedge clk);
        key = 3'b111;
        repeat (10) @(negedge clk);
        total_cnt++;
        if (key_irq !== 1'b0) $display("FAIL glitch_irq: got %b expected 0", key_irq); else pass_cnt++;
        access(1'b0, 6'h04, '0, rd);
        total_cnt++;
        if (rd !== 32'h0) $display("FAIL glitch_key_read: got %h expected 0", rd); else pass_cnt++;
        access(1'b0, 6'h08, '0, rd);
        total_cnt++;
        if (rd !== 32'h0) $display("FAIL glitch_evt_read: got %h expected 0", rd); else pass_cnt++;
    endtask

    task automatic test_display();
        logic [31:0] rd;
        access(1'b1, 6'h10, 32'h05, rd); dig_m[0] = 5'h05;
        total_cnt++;
        if (hex0 !== 7'b0010010) $display("FAIL hex0_five: got %b expected 0010010", hex0); else pass_cnt++;
        access(1'b1, 6'h24, 32'h10, rd); dig_m[5] = 5'h10;
        total_cnt++;
        if (hex5 !== 7'h7F) $display("FAIL hex5_blank: got %h expected 7f", hex5); else pass_cnt++;
        access(1'b1, 6'h14, 32'h0F, rd); dig_m[1] = 5'h0F;
        total_cnt++;
        if (hex1 !== 7'b0001110) $display("FAIL hex1_f: got %b expected 0001110", hex1); else pass_cnt++;
        access(1'b1, 6'h0C, 32'hFFFF_FFFF, rd); led_m = 10'h3FF;
        total_cnt++;
        if (led !== 10'h3FF) $display("FAIL led_pins: got %h expected 3ff", led); else pass_cnt++;
        access(1'b0, 6'h0C, '0, rd);
        total_cnt++;
        if (rd !== 32'h3FF) $display("FAIL led_read: got %h expected 3ff", rd); else pass_cnt++;
    endtask

    task automatic test_set_wins_unmapped();
        logic [31:0] rd;
        key = 3'b110;
        repeat (1 + DB_CYCLES) @(negedge clk);
        access(1'b1, 6'h08, 32'h1, rd);
        total_cnt++;
        if (key_irq !== 1'b1) $display("FAIL set_wins_irq: got %b expected 1", key_irq); else pass_cnt++;
        access(1'b0, 6'h08, '0, rd);
        total_cnt++;
        if (rd !== 32'h1) $display("FAIL set_wins_evt: got %h expected 1", rd); else pass_cnt++;
        access(1'b1, 6'h08, 32'h1, rd);
        access(1'b0, 6'h08, '0, rd);
        total_cnt++;
        if (rd !== 32'h0) $display("FAIL late_w1c_evt: got %h expected 0", rd); else pass_cnt++;
        key = 3'b111;
        repeat (2 * DB_CYCLES) @(negedge clk);
        access(1'b1, 6'h3C, 32'hFFFF_FFFF, rd);
        access(1'b0, 6'h3C, '0, rd);
        total_cnt++;
        if (rd !== 32'h0) $display("FAIL unmapped_read: got %h expected 0", rd); else pass_cnt++;
        total_cnt++;
        if (led !== led_m || key_irq !== 1'b0)
            $display("FAIL unmapped_write_led: led=%h irq=%b expected %h/0", led, key_irq, led_m);
        else pass_cnt++;
        for (int i = 0; i < 6; i++) begin
            total_cnt++;
            if (hex_pins[i] !== exp_hex(dig_m[i]))
                $display("FAIL unmapped_write_hex%0d: got %h expected %h", i, hex_pins[i], exp_hex(dig_m[i]));
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, wd;
        logic [9:0]  sw_val;
        logic [5:0]  addr;
        int          idx;
        for (int n = 0; n < 24; n++) begin
            wd = $urandom;
            case ($urandom_range(0, 3))
                0: begin
                    sw_val = 10'($urandom);
                    sw = sw_val;
                    repeat (2 + DB_CYCLES) @(negedge clk);
                    access(1'b0, 6'h00 | 6'($urandom_range(0, 3)), '0, rd);
                    total_cnt++;
                    if (rd !== {22'h0, sw_val}) $display("FAIL rand_sw: got %h expected %h", rd, sw_val);
                    else pass_cnt++;
                end
                1: begin
                    access(1'b1, 6'h0C | 6'($urandom_range(0, 3)), wd, rd);
                    led_m = wd[9:0];
                    access(1'b0, 6'h0C, '0, rd);
                    total_cnt++;
                    if (led !== led_m || rd !== {22'h0, led_m})
                        $display("FAIL rand_led: pins=%h read=%h expected %h", led, rd, led_m);
                    else pass_cnt++;
                end
                2: begin
                    idx = $urandom_range(0, 5);
                    addr = 6'(16 + 4 * idx) | 6'($urandom_range(0, 3));
                    access(1'b1, addr, wd, rd);
                    dig_m[idx] = wd[4:0];
                    access(1'b0, addr, '0, rd);
                    total_cnt++;
                    if (rd !== {27'h0, dig_m[idx]})
                        $display("FAIL rand_hex_read%0d: got %h expected %h", idx, rd, dig_m[idx]);
                    else pass_cnt++;
                    for (int i = 0; i < 6; i++) begin
                        total_cnt++;
                        if (hex_pins[i] !== exp_hex(dig_m[i]))
                            $display("FAIL rand_hex_pin%0d: got %h expected %h", i, hex_pins[i], exp_hex(dig_m[i]));
                        else pass_cnt++;
                    end
                end
                default: begin
                    addr = 6'($urandom_range(40, 63));
                    access(1'b1, addr, wd, rd);
                    access(1'b0, addr, '0, rd);
                    total_cnt++;
                    if (rd !== 32'h0 || led !== led_m)
                        $display("FAIL rand_unmapped %h: read=%h led=%h expected 0/%h", addr, rd, led, led_m);
                    else pass_cnt++;
                end
            endcase
        end
    endtask

    task automatic test_mid_reset();
        logic [31:0] rd;
        key = 3'b101;
        repeat (2 * DB_CYCLES) @(negedge clk);
        access(1'b1, 6'h10, 32'h03, rd);
        total_cnt++;
        if (key_irq !== 1'b1 || hex0 !== 7'b0110000)
            $display("FAIL pre_reset_state: irq=%b hex0=%b expected 1/0110000", key_irq, hex0);
        else pass_cnt++;
        io_cs = 1'b1; io_we = 1'b1; io_addr = 6'h0C; io_wdata = 32'h155;
        @(posedge clk); #2;
        total_cnt++;
        if (io_ready !== 1'b1) $display("FAIL pre_reset_ack: got %b expected 1", io_ready); else pass_cnt++;
        reset = 1'b1;
        #1;
        total_cnt++;
        if (io_ready !== 1'b0 || led !== 10'h0 || key_irq !== 1'b0 || io_rdata !== 32'h0)
            $display("FAIL mid_reset_outputs: ready=%b led=%h irq=%b rdata=%h expected all 0",
                     io_ready, led, key_irq, io_rdata);
        else pass_cnt++;
        for (int i = 0; i < 6; i++) begin
            total_cnt++;
            if (hex_pins[i] !== 7'h7F) $display("FAIL mid_reset_hex%0d: got %h expected 7f", i, hex_pins[i]);
            else pass_cnt++;
        end
        io_cs = 1'b0; io_we = 1'b0; key = 3'b111;
        @(negedge clk);
        reset = 1'b0;
        led_m = '0;
        for (int i = 0; i < 6; i++) dig_m[i] = 5'h10;
        repeat (2) @(negedge clk);
        access(1'b0, 6'h0C, '0, rd);
        total_cnt++;
        if (rd !== 32'h0) $display("FAIL dropped_access_led: got %h expected 0", rd); else pass_cnt++;
        access(1'b0, 6'h08, '0, rd);
        total_cnt++;
        if (rd !== 32'h0 || key_irq !== 1'b0)
            $display("FAIL post_reset_evt: evt=%h irq=%b expected 0/0", rd, key_irq);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_sw();
        test_key_event();
        test_glitch();
        test_display();
        test_set_wins_unmapped();
        test_random();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
